// File: rtl/sc_sample_feeder.sv
// -----------------------------------------------------------------------------
// sc_sample_feeder
// Buffers incoming binary samples in a small FIFO and presents one sample per
// stochastic evaluation frame to the FIR core. Each time a new sample is
// loaded, a one-cycle start pulse restarts the core's RNG/VDC sequence. If the
// FIFO is non-empty when a frame ends, the next frame follows with no gap.
//
// Parameters
//   N      stochastic precision; samples are N+1 bits wide
//   FRAME  clocks per evaluation frame (power of two, >= 4)
//   DEPTH  FIFO depth in samples (power of two, >= 2)
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   s_data      incoming sample
//   s_valid     s_data is valid
//   s_ready     FIFO can accept a sample this cycle
//   in          sample presented to the core, held for the whole frame
//   start       one-cycle pulse in the first cycle of each frame
//   frame_done  high in the last cycle of each frame
//   underrun    one-cycle pulse after a frame ends with the FIFO empty
//   busy        high while a frame is running
//   fifo_count  current FIFO occupancy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sc_sample_feeder #(
  parameter int unsigned N     = 12,
  parameter int unsigned FRAME = 4096,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N:0]               s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [N:0]               in,
  output logic                     start,
  output logic                     frame_done,
  output logic                     underrun,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned DW = N + 1;
  localparam int unsigned FW = $clog2(FRAME);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  // Registered state
  logic [0:0]    r_state;
  logic [FW-1:0] r_fcnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_in;
  logic          r_start;
  logic          r_frame_done;
  logic          r_underrun;
  logic          r_busy;
  logic          r_s_ready;
  logic [DW-1:0] r_mem [DEPTH];

  // Next-state values
  logic [0:0]    w_state_nxt;
  logic [FW-1:0] w_fcnt_nxt;
  logic [AW-1:0] w_wptr_nxt;
  logic [AW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [DW-1:0] w_in_nxt;
  logic          w_start_nxt;
  logic          w_frame_done_nxt;
  logic          w_underrun_nxt;
  logic          w_busy_nxt;
  logic          w_s_ready_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_frame_end;
  logic          w_fifo_empty;

  // A full FIFO refuses pushes even when a pop happens in the same cycle,
  // because acceptance is decoded from the registered occupancy only.
  assign w_push       = s_valid && r_s_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_frame_end  = (r_state == S_RUN) && (r_fcnt == FCNT_LAST);

  // Next-state and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_fcnt_nxt     = r_fcnt;
    w_pop          = 1'b0;
    w_underrun_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_RUN;
          w_fcnt_nxt  = '0;
        end
      end
      S_RUN: begin
        if (w_frame_end) begin
          w_fcnt_nxt = '0;
          if (!w_fifo_empty) begin
            // back-to-back frame, no idle gap
            w_pop = 1'b1;
          end else begin
            w_state_nxt    = S_IDLE;
            w_underrun_nxt = 1'b1;
          end
        end else begin
          w_fcnt_nxt = r_fcnt + FW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fcnt_nxt  = '0;
      end
    endcase

    w_wptr_nxt = w_push ? (r_wptr + AW'(1)) : r_wptr;
    w_rptr_nxt = w_pop  ? (r_rptr + AW'(1)) : r_rptr;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    w_in_nxt    = w_pop ? r_mem[r_rptr] : r_in;
    w_start_nxt = w_pop;

    // Status outputs are registered copies of what the next state decodes to.
    w_frame_done_nxt = (w_state_nxt == S_RUN) && (w_fcnt_nxt == FCNT_LAST);
    w_busy_nxt       = (w_state_nxt == S_RUN);
    w_s_ready_nxt    = (w_count_nxt < CNT_FULL);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fcnt       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_in         <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_busy       <= 1'b0;
      r_s_ready    <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_fcnt       <= w_fcnt_nxt;
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_in         <= w_in_nxt;
      r_start      <= w_start_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_underrun   <= w_underrun_nxt;
      r_busy       <= w_busy_nxt;
      r_s_ready    <= w_s_ready_nxt;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= s_data;
    end
  end

  assign s_ready    = r_s_ready;
  assign in         = r_in;
  assign start      = r_start;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_sc_sample_feeder.sv
`timescale 1ns/1ps

module tb_sc_sample_feeder;

  localparam int N     = 12;
  localparam int FRAME = 16;
  localparam int DEPTH = 4;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic [N:0]    s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [N:0]    dout;
  logic          start, frame_done, underrun, busy;
  logic [2:0]    fifo_count;

  // Default-parameter instance (FRAME=4096, DEPTH=4, N=12)
  logic [12:0]   d_s_data  = '0;
  logic          d_s_valid = 1'b0;
  logic          d_s_ready;
  logic [12:0]   d_in;
  logic          d_start, d_frame_done, d_underrun, d_busy;
  logic [2:0]    d_fifo_count;

  sc_sample_feeder #(.N(N), .FRAME(FRAME), .DEPTH(DEPTH)) u_dut (
    .clock(clock), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .in(dout), .start(start), .frame_done(frame_done),
    .underrun(underrun), .busy(busy), .fifo_count(fifo_count)
  );

  sc_sample_feeder u_dut_def (
    .clock(clock), .reset(reset), .s_data(d_s_data), .s_valid(d_s_valid),
    .s_ready(d_s_ready), .in(d_in), .start(d_start), .frame_done(d_frame_done),
    .underrun(d_underrun), .busy(d_busy), .fifo_count(d_fifo_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is described by the cycle it began in; the position inside the
  // frame is just the distance from that cycle.
  logic [N:0] q[$];
  bit         m_run;
  int         m_start_cyc;
  int         cyc;
  logic [N:0] m_in;
  bit         m_underrun;
  bit         mp_push, mp_end, mp_pop;

  initial begin
    m_run = 0; m_start_cyc = -1000; cyc = 0; m_in = '0; m_underrun = 0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        q.delete();
        m_run = 0; m_start_cyc = -1000; m_in = '0; m_underrun = 0;
      end else begin
        mp_push    = s_valid && (q.size() < DEPTH);
        mp_end     = m_run && (cyc - m_start_cyc == FRAME - 1);
        mp_pop     = (q.size() > 0) && (!m_run || mp_end);
        m_underrun = mp_end && (q.size() == 0);
        if (mp_pop) begin
          m_in        = q.pop_front();
          m_run       = 1;
          m_start_cyc = cyc + 1;
        end else if (mp_end) begin
          m_run = 0;
        end
        if (mp_push) q.push_back(s_data);
        cyc++;
      end
    end
  end

  // ---------------- compare process + observation log ----------------
  bit   cmp_en = 0;
  int   tb_cyc = 0;
  int   st_cyc[$];
  int   st_val[$];
  int   ur_n = 0;
  int   max_cnt = 0;
  bit   saw_not_ready = 0;

  initial begin
    forever begin
      @(negedge clock);
      tb_cyc++;
      if (cmp_en && !reset) begin
        check("start",      32'(start),      32'(m_run && (cyc == m_start_cyc)));
        check("frame_done", 32'(frame_done), 32'(m_run && (cyc - m_start_cyc == FRAME - 1)));
        check("busy",       32'(busy),       32'(m_run));
        check("underrun",   32'(underrun),   32'(m_underrun));
        check("s_ready",    32'(s_ready),    32'(q.size() < DEPTH));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("in",         32'(dout),       32'(m_in));
        if (start) begin
          st_cyc.push_back(tb_cyc);
          st_val.push_back(int'(dout));
        end
        if (underrun) ur_n++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (!s_ready) saw_not_ready = 1;
      end
    end
  end

  // ---------------- stimulus helpers (called right after a negedge) --------
  task automatic send(input logic [N:0] d);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) check("send_timeout", 32'(0), 32'(1));
    @(negedge clock);
    s_valid = 1'b0;
  endtask

  task automatic wait_underrun(input int limit);
    int t;
    t = 0;
    while (!underrun && t < limit) begin
      @(negedge clock);
      t++;
    end
    if (t >= limit) check("underrun_timeout", 32'(0), 32'(1));
    #1;
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_val.delete();
    ur_n = 0;
    max_cnt = 0;
    saw_not_ready = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    // reset state
    check("rst_busy",    32'(busy),       32'(0));
    check("rst_s_ready", 32'(s_ready),    32'(1));
    check("rst_count",   32'(fifo_count), 32'(0));
    check("rst_in",      32'(dout),       32'(0));
    cmp_en = 1;

    // Single sample: load two edges after presenting, frame of 16, underrun after
    send(13'h0A5);
    @(negedge clock);
    check("t1_start", 32'(start), 32'(1));
    check("t1_in",    32'(dout),  32'h0A5);
    check("t1_busy",  32'(busy),  32'(1));
    repeat (14) @(negedge clock);
    check("t1_fd_early", 32'(frame_done), 32'(0));
    @(negedge clock);
    check("t1_fd",    32'(frame_done), 32'(1));
    @(negedge clock);
    check("t1_ur",    32'(underrun), 32'(1));
    check("t1_idle",  32'(busy),     32'(0));
    check("t1_hold",  32'(dout),     32'h0A5);
    @(negedge clock);
    check("t1_ur_off", 32'(underrun), 32'(0));

    // Back-to-back frames
    clear_log();
    send(13'h001); send(13'h002); send(13'h003);
    wait_underrun(100);
    check("t2_nstart", 32'(st_cyc.size()), 32'(3));
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_in%0d", i), (i < st_val.size()) ? 32'(st_val[i]) : 32'hxxxxxxxx, 32'(i + 1));
    for (int i = 1; i < 3; i++)
      check($sformatf("t2_gap%0d", i),
            (i < st_cyc.size()) ? 32'(st_cyc[i] - st_cyc[i-1]) : 32'hxxxxxxxx, 32'(16));
    check("t2_ur_n", 32'(ur_n), 32'(1));
    check("t2_ur_at", 32'(tb_cyc), (st_cyc.size() == 3) ? 32'(st_cyc[2] + 16) : 32'hxxxxxxxx);
    @(negedge clock);

    // Full FIFO: six samples with valid held high
    clear_log();
    for (int i = 0; i < 6; i++) send(13'(12'h100 + i));
    wait_underrun(200);
    check("t3_max",     32'(max_cnt),       32'(4));
    check("t3_notrdy",  32'(saw_not_ready), 32'(1));
    check("t3_nstart",  32'(st_val.size()), 32'(6));
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_in%0d", i), (i < st_val.size()) ? 32'(st_val[i]) : 32'hxxxxxxxx, 32'(32'h100 + i));
    @(negedge clock);

    // Frame-end collision: push in the frame_done cycle with FIFO empty
    send(13'h0C3);
    begin
      int t;
      t = 0;
      while (!frame_done && t < 100) begin
        @(negedge clock);
        t++;
      end
      if (t >= 100) check("t4_fd_timeout", 32'(0), 32'(1));
    end
    s_data = 13'h0C4;
    s_valid = 1'b1;
    @(negedge clock);
    s_valid = 1'b0;
    check("t4_ur",    32'(underrun), 32'(1));
    check("t4_idle",  32'(busy),     32'(0));
    check("t4_nost",  32'(start),    32'(0));
    @(negedge clock);
    check("t4_start", 32'(start), 32'(1));
    check("t4_in",    32'(dout),  32'h0C4);
    wait_underrun(100);
    @(negedge clock);

    // Reset mid-frame at fcnt=7 with two samples queued
    send(13'h011);
    @(negedge clock);
    check("t5_start", 32'(start), 32'(1));
    send(13'h022);
    send(13'h033);
    repeat (5) @(negedge clock);
    check("t5_q2", 32'(fifo_count), 32'(2));
    #2 reset = 1'b1;
    #1;
    check("t5_r_in",    32'(dout),       32'(0));
    check("t5_r_start", 32'(start),      32'(0));
    check("t5_r_fd",    32'(frame_done), 32'(0));
    check("t5_r_ur",    32'(underrun),   32'(0));
    check("t5_r_busy",  32'(busy),       32'(0));
    check("t5_r_cnt",   32'(fifo_count), 32'(0));
    check("t5_r_rdy",   32'(s_ready),    32'(1));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_log();
    repeat (40) @(negedge clock);
    #1;
    check("t5_nostart", 32'(st_cyc.size()), 32'(0));
    check("t5_idle",    32'(busy),          32'(0));

    // Wrap-around: 20 samples streamed continuously
    clear_log();
    for (int i = 0; i < 20; i++) send(13'(12'h200 + i * 3));
    wait_underrun(400);
    check("t6_nstart", 32'(st_val.size()), 32'(20));
    for (int i = 0; i < 20; i++)
      check($sformatf("t6_in%0d", i), (i < st_val.size()) ? 32'(st_val[i]) : 32'hxxxxxxxx, 32'(32'h200 + i * 3));
    check("t6_max", 32'(max_cnt <= 4), 32'(1));
    @(negedge clock);

    // Default parameters: FRAME=4096
    check("d_idle",  32'(d_busy),    32'(0));
    check("d_ready", 32'(d_s_ready), 32'(1));
    d_s_data  = 13'h155;
    d_s_valid = 1'b1;
    @(negedge clock);
    d_s_valid = 1'b0;
    @(negedge clock);
    check("d_start", 32'(d_start), 32'(1));
    check("d_in",    32'(d_in),    32'h155);
    repeat (4094) @(negedge clock);
    check("d_fd_early", 32'(d_frame_done), 32'(0));
    @(negedge clock);
    check("d_fd",    32'(d_frame_done), 32'(1));
    @(negedge clock);
    check("d_ur",    32'(d_underrun), 32'(1));
    check("d_busy",  32'(d_busy),     32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
